// File: rtl/accum_pkg.sv
// ---------------------------------------------------------------------------
// Module   : accum_pkg
// Purpose  : Shared types and constants for the double-accumulate feed path.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package accum_pkg;

    // Internal double: sign [63], exponent {[64],[62:52]}, mantissa {[51:33],[31:0]}
    typedef logic [67:0] dbl68_t;

    localparam int ACC_NB     = 108;
    localparam int ACC_EXP_HI = 64;
    localparam int ACC_SGN    = 63;
    localparam int ACC_IDX_W  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_ISSUE = 2'd2
    } feed_st_t;

    // Pointer width that stays legal for a single-entry FIFO.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/accum_res_fifo.sv
// ---------------------------------------------------------------------------
// Module   : accum_res_fifo
// Purpose  : Small valid/ready result FIFO with occupancy count output.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module accum_res_fifo
    import accum_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(DEPTH-1);
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop frees the slot in the same cycle, so push into a full FIFO is fine with it.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_FULL) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/accum_dbl_feed.sv
// ---------------------------------------------------------------------------
// Module   : accum_dbl_feed
// Purpose  : Collects A + up to 108 addends per batch, issues to the double
//            accumulator under result-FIFO credit, queues returned results.
//            Optional partial-batch timeout: define ACCUM_FEED_TIMEOUT_EN.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module accum_dbl_feed
    import accum_pkg::*;
#(
    parameter int     RES_DEPTH = 4,
    parameter int     ACC_LAT   = 8,
    parameter dbl68_t PAD_VAL   = '0,
    parameter int     TMO_CYC   = 64
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  dbl68_t                  op_data,
    input  logic                    op_last,
    output dbl68_t                  acc_A,
    output dbl68_t [ACC_NB-1:0]     acc_B,
    output logic                    acc_din_en,
    input  dbl68_t                  acc_res,
    input  logic                    acc_res_en,
    output logic                    out_valid,
    output dbl68_t                  out_data,
    input  logic                    out_ready,
    output logic                    err_orphan
);

    localparam int INF_W = $clog2(RES_DEPTH+1);
    localparam logic [ACC_IDX_W-1:0] c_IDX_LAST = ACC_IDX_W'(ACC_NB-1);
    localparam logic [INF_W:0]       c_DEPTH    = (INF_W+1)'(RES_DEPTH);

    if (RES_DEPTH < 1 || ACC_LAT < 2 || TMO_CYC < 2) begin : g_param_check
        $error("accum_dbl_feed: RES_DEPTH >= 1, ACC_LAT >= 2, TMO_CYC >= 2 required");
    end

    feed_st_t               r_state;
    logic [ACC_IDX_W-1:0]   r_idx;
    logic [INF_W-1:0]       r_inflight;
    logic                   r_cap;
    logic                   r_err_orphan;
    dbl68_t                 r_acc_A;
    dbl68_t [ACC_NB-1:0]    r_acc_B;

    logic                   w_accept;
    logic                   w_credit_ok;
    logic                   w_issue;
    logic                   w_cap_push;
    logic                   w_tmo_hit;
    logic [INF_W-1:0]       w_fifo_count;

    assign op_ready    = !rst && (r_state != ST_ISSUE);
    assign w_accept    = op_valid && op_ready;
    assign w_credit_ok = ({1'b0, w_fifo_count} + {1'b0, r_inflight}) < c_DEPTH;
    assign w_issue     = (r_state == ST_ISSUE) && w_credit_ok;
    assign w_cap_push  = r_cap && (r_inflight != '0);

`ifdef ACCUM_FEED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC+1);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Preloaded with 1 on accept so the count includes the accept cycle and
    // the issue strobe lands TMO_CYC cycles after the last accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= TMO_W'(1);
        end else if (r_state == ST_FILL) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo_hit = (r_state == ST_FILL) && !w_accept &&
                       (r_tmo_cnt == TMO_W'(TMO_CYC-1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_acc_A <= '0;
            r_acc_B <= {ACC_NB{PAD_VAL}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_acc_A <= op_data;
                        r_acc_B <= {ACC_NB{PAD_VAL}};
                        r_idx   <= '0;
                        r_state <= op_last ? ST_ISSUE : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_acc_B[r_idx] <= op_data;
                        r_idx          <= r_idx + 1'b1;
                        if (op_last || (r_idx == c_IDX_LAST)) begin
                            r_state <= ST_ISSUE;
                        end
                    end else if (w_tmo_hit) begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // res_en leads the data by one cycle; the registered copy marks data-valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap        <= 1'b0;
            r_inflight   <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_cap      <= acc_res_en;
            r_inflight <= r_inflight + INF_W'(w_issue) - INF_W'(w_cap_push);
            if (r_cap && (r_inflight == '0)) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    accum_res_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH ($bits(dbl68_t))
    ) u_res_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_cap_push),
        .i_push_data (acc_res),
        .i_pop       (out_ready),
        .o_head      (out_data),
        .o_valid     (out_valid),
        .o_count     (w_fifo_count)
    );

    assign acc_A      = r_acc_A;
    assign acc_B      = r_acc_B;
    assign acc_din_en = w_issue;
    assign err_orphan = r_err_orphan;

endmodule

`default_nettype wire

// File: tb/tb_accum_dbl_feed.sv
// ---------------------------------------------------------------------------
// Module   : tb_accum_dbl_feed
// Purpose  : Directed scoreboard bench for accum_dbl_feed with an
//            accumulator responder (res_en at +7, data at +8).
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_accum_dbl_feed;
    import accum_pkg::*;

    typedef dbl68_t [ACC_NB-1:0] bvec_t;

    localparam int     RES_DEPTH = 4;
    localparam dbl68_t PAD       = 68'h5_0000_0000_0000_1234;

    logic   clk = 1'b0;
    logic   rst;
    logic   op_valid, op_ready, op_last;
    dbl68_t op_data;
    dbl68_t acc_A;
    bvec_t  acc_B;
    logic   acc_din_en;
    dbl68_t acc_res;
    logic   acc_res_en;
    logic   out_valid, out_ready, err_orphan;
    dbl68_t out_data;

    accum_dbl_feed #(
        .RES_DEPTH (RES_DEPTH),
        .ACC_LAT   (8),
        .PAD_VAL   (PAD),
        .TMO_CYC   (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_data    (op_data),
        .op_last    (op_last),
        .acc_A      (acc_A),
        .acc_B      (acc_B),
        .acc_din_en (acc_din_en),
        .acc_res    (acc_res),
        .acc_res_en (acc_res_en),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int din_cnt = 0;
    int last_iss_cyc = 0;
    int last_acc_cyc = 0;
    logic inj_res_en = 1'b0;

    // Expected batches and results from the stimulus side; accumulator pipeline.
    dbl68_t bq_A[$];
    bvec_t  bq_B[$];
    dbl68_t res_q[$];
    int     pend_cyc[$];
    dbl68_t pend_res[$];

    dbl68_t m_A;
    bvec_t  m_B;
    int     m_idx = 0;
    logic   m_in_fill = 1'b0;

    function automatic dbl68_t acc_model(input dbl68_t a, input bvec_t b);
        dbl68_t s = a;
        for (int i = 0; i < ACC_NB; i++) s = s + (b[i] ^ dbl68_t'(i));
        return s;
    endfunction

    task automatic check(input string tag, input dbl68_t obs, input dbl68_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input bvec_t obs, input bvec_t exp);
        int slot = 0;
        checks++;
        for (int i = ACC_NB-1; i >= 0; i--) if (obs[i] !== exp[i]) slot = i;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s slot=%0d observed=%0h expected=%0h", tag, slot, obs[slot], exp[slot]);
        end
    endtask

    task automatic model_close();
        bq_A.push_back(m_A);
        bq_B.push_back(m_B);
        res_q.push_back(acc_model(m_A, m_B));
        m_in_fill = 1'b0;
    endtask

    task automatic model_beat(input dbl68_t d, input logic last);
        if (!m_in_fill) begin
            m_A   = d;
            m_B   = {ACC_NB{PAD}};
            m_idx = 0;
            if (last) model_close();
            else m_in_fill = 1'b1;
        end else begin
            m_B[m_idx] = d;
            if (last || m_idx == ACC_NB-1) model_close();
            m_idx++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input dbl68_t d, input logic last);
        int n = 0;
        logic ok = 1'b0;
        op_valid = 1'b1; op_data = d; op_last = last;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (op_ready === 1'b1) ok = 1'b1;
            n++;
        end
        if (ok) begin
            last_acc_cyc = cyc;
            model_beat(d, last);
        end else begin
            checks++; failures++;
            $error("FAIL send_accept timeout observed=0 expected=1");
        end
        @(posedge clk); #1;
        op_valid = 1'b0; op_last = 1'b0;
    endtask

    task automatic wait_din(input int target, input int budget, input string tag);
        int n = 0;
        while (din_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        assert (din_cnt >= target) else begin
            failures++;
            $error("FAIL %s issues=%0d expected=%0d", tag, din_cnt, target);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((res_q.size() != 0 || pend_cyc.size() != 0) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        assert (res_q.size() == 0) else begin
            failures++;
            $error("FAIL %s pending_results=%0d expected=0", tag, res_q.size());
        end
        @(posedge clk); #1;
    endtask

    // Issue monitor: batch contents against the scoreboard, feeds accumulator.
    always @(negedge clk) begin
        if (acc_din_en === 1'b1) begin
            din_cnt++;
            last_iss_cyc = cyc;
            if (bq_A.size() == 0) begin
                checks++; failures++;
                $error("FAIL unexpected_issue observed=1 expected=0");
            end else begin
                check("issue_A", acc_A, bq_A.pop_front());
                check_b("issue_B", acc_B, bq_B.pop_front());
            end
            pend_cyc.push_back(cyc);
            pend_res.push_back(acc_model(acc_A, acc_B));
        end
    end

    // Result monitor: every popped head against the scoreboard.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (res_q.size() == 0) begin
                checks++; failures++;
                $error("FAIL unexpected_result observed=%0h expected=none", out_data);
            end else begin
                check("result", out_data, res_q.pop_front());
            end
        end
    end

    // Accumulator responder: res_en at issue+7, result data at issue+8.
    initial begin
        acc_res_en = 1'b0;
        acc_res    = '0;
        forever begin
            @(posedge clk); #2;
            acc_res_en = inj_res_en;
            foreach (pend_cyc[i]) if (pend_cyc[i] + 7 == cyc) acc_res_en = 1'b1;
            if (pend_cyc.size() != 0 && pend_cyc[0] + 8 == cyc) begin
                acc_res = pend_res[0];
                void'(pend_cyc.pop_front());
                void'(pend_res.pop_front());
            end
        end
    end

    initial begin
        int n0;
        int t;
        int n;
        rst = 1'b1; op_valid = 1'b0; op_data = '0; op_last = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_op_ready", 68'(op_ready), 68'd0);
        check("rst_din_en", 68'(acc_din_en), 68'd0);
        check("rst_acc_A", acc_A, 68'd0);
        check_b("rst_acc_B", acc_B, {ACC_NB{PAD}});
        check("rst_out_valid", 68'(out_valid), 68'd0);
        check("rst_out_data", out_data, 68'd0);
        check("rst_err_orphan", 68'(err_orphan), 68'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("op_ready_after_rst", 68'(op_ready), 68'd1);
        @(posedge clk); #1;

        // A = 1.0 plus three addends; result latency from issue
        n0 = din_cnt;
        send(68'h0_3FF0_0000_0000_0000, 1'b0);
        send(68'h0_4000_0000_0000_0000, 1'b0);
        send(68'h0_3FE0_0000_0000_0000, 1'b0);
        send(68'h0_C008_0000_0000_0000, 1'b1);
        wait_din(n0 + 1, 20, "basic_issue");
        t = last_iss_cyc;
        check("basic_B3_pad", acc_B[3], PAD);
        check("basic_B107_pad", acc_B[107], PAD);
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        check("res_latency", 68'(cyc), 68'(t + 9));
        check("basic_one_pulse", 68'(din_cnt - n0), 68'd1);
        @(posedge clk); #1;
        drain("basic_drain");

        // 109 beats without op_last: slot 107 closes the batch
        n0 = din_cnt;
        for (int i = 0; i < 109; i++) send({4'h1, 32'hA5A5_0000, 32'(i * 7 + 3)}, 1'b0);
        check("full_issue_op_ready", 68'(op_ready), 68'd0);
        check("full_issue_strobe", 68'(acc_din_en), 68'd1);
        send(68'h2_1234_5678_9ABC_DEF0, 1'b1);
        wait_din(n0 + 2, 20, "full_next_A");
        drain("full_drain");

        // Credit stall: five A-only batches with the consumer stalled
        out_ready = 1'b0;
        n0 = din_cnt;
        for (int k = 0; k < 5; k++) send(68'h7_0000_0000_0000_0000 + dbl68_t'(k * 17), 1'b1);
        repeat (30) @(negedge clk);
        #1;
        check("credit_stall_issues", 68'(din_cnt - n0), 68'd4);
        check("credit_stall_valid", 68'(out_valid), 68'd1);
        check("credit_stall_op_ready", 68'(op_ready), 68'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("issue_after_pop", 68'(acc_din_en), 68'd1);
        out_ready = 1'b1;
        wait_din(n0 + 5, 20, "credit_fifth");
        drain("credit_drain");

        // Orphan result with nothing in flight
        inj_res_en = 1'b1;
        @(posedge clk); #1;
        inj_res_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("orphan_flag", 68'(err_orphan), 68'd1);
        check("orphan_no_push", 68'(out_valid), 68'd0);
        n0 = din_cnt;
        send(68'h3_0000_1111_2222_3333, 1'b1);
        wait_din(n0 + 1, 20, "orphan_next");
        drain("orphan_drain");
        check("orphan_sticky", 68'(err_orphan), 68'd1);

        // Reset in FILL with idx = 50
        send(68'h0_4010_0000_0000_0000, 1'b0);
        for (int i = 0; i < 50; i++) send({36'h0_0BAD_0000, 32'(i + 100)}, 1'b0);
        rst = 1'b1;
        m_in_fill = 1'b0;
        #1;
        check("midrst_op_ready", 68'(op_ready), 68'd0);
        check("midrst_acc_A", acc_A, 68'd0);
        check_b("midrst_acc_B", acc_B, {ACC_NB{PAD}});
        check("midrst_out_valid", 68'(out_valid), 68'd0);
        check("midrst_err_orphan", 68'(err_orphan), 68'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n0 = din_cnt;
        send(68'h0_3FF0_0000_0000_0001, 1'b0);
        send(68'h0_0000_0000_0000_0011, 1'b0);
        send(68'h0_0000_0000_0000_0022, 1'b0);
        send(68'h0_0000_0000_0000_0033, 1'b1);
        wait_din(n0 + 1, 20, "postrst_issue");
        check("postrst_B50_pad", acc_B[50], PAD);
        drain("postrst_drain");

        // Partial batch left idle
        n0 = din_cnt;
        send(68'h0_3FF8_0000_0000_0000, 1'b0);
        send(68'h0_0000_0000_0000_0101, 1'b0);
        send(68'h0_0000_0000_0000_0202, 1'b0);
`ifdef ACCUM_FEED_TIMEOUT_EN
        model_close();
        wait_din(n0 + 1, 200, "timeout_issue");
        check("timeout_issue_cyc", 68'(last_iss_cyc), 68'(last_acc_cyc + 64));
`else
        repeat (200) @(negedge clk);
        #1;
        check("no_timeout_issue", 68'(din_cnt - n0), 68'd0);
        @(posedge clk); #1;
        send(68'h0_0000_0000_0000_0303, 1'b1);
        wait_din(n0 + 1, 20, "close_after_idle");
`endif
        drain("final_drain");
        check("final_batches_left", 68'(bq_A.size()), 68'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
